trim_sequential: RTL and testbench

TRIM_SEQUENTIAL -- requirements
Module: trim_sequential

---
 rtl/trim_pkg.sv | 18 +
 rtl/fullMultiplier.sv | 32 +++
 rtl/trim_sequential.sv | 155 +++++++++++++++
 tb/tb_trim_sequential.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/trim_pkg.sv
// Shared definitions for the trim_sequential gain-compensation block.
package trim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } trim_state_t;

    // Edges from the strobe edge to the commit edge: one issue edge per
    // channel, the multiplier pipeline, one rounding stage and the commit.
    function automatic int unsigned latency(input int unsigned num_channels,
                                            input int unsigned mult_latency);
        return num_channels + mult_latency + 2;
    endfunction

endpackage

// File: rtl/fullMultiplier.sv
// Unsigned pipelined multiplier: p is a*b delayed by NUM_PIPELINE_LEVELS edges.
module fullMultiplier #(
    parameter int A_WIDTH             = 26,
    parameter int B_WIDTH             = 27,
    parameter int NUM_PIPELINE_LEVELS = 6
) (
    input  logic                       clk,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    output logic [A_WIDTH+B_WIDTH-1:0] p
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    logic [P_WIDTH-1:0]                          a_ext;
    logic [P_WIDTH-1:0]                          b_ext;
    logic [NUM_PIPELINE_LEVELS-1:0][P_WIDTH-1:0] stage;

    assign a_ext = {{B_WIDTH{1'b0}}, a};
    assign b_ext = {{A_WIDTH{1'b0}}, b};

    // Product enters the first stage and shifts down the pipeline.
    always_ff @(posedge clk) begin
        stage[0] <= a_ext * b_ext;
        for (int unsigned i = 1; i < NUM_PIPELINE_LEVELS; i++) begin
            stage[i] <= stage[i-1];
        end
    end

    assign p = stage[NUM_PIPELINE_LEVELS-1];

endmodule

// File: rtl/trim_sequential.sv
// Per-channel gain compensation of magnitudes using one shared pipelined
// multiplier, issuing one channel per clock and committing all results at once.
module trim_sequential
    import trim_pkg::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int MAG_WIDTH      = 26,
    parameter int GAIN_WIDTH     = 27,
    parameter int GAIN_FRAC_BITS = GAIN_WIDTH - 1,
    parameter int MULT_LATENCY   = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              strobe,
    input  logic [MAG_WIDTH*NUM_CHANNELS-1:0]  magnitudes,
    input  logic [GAIN_WIDTH*NUM_CHANNELS-1:0] gains,
    input  logic                              gainsStrobe,
    input  logic                              overrunClear,
    output logic                              busy,
    output logic                              overrun,
    output logic                              trimmedToggle,
    output logic [MAG_WIDTH*NUM_CHANNELS-1:0]  trimmed,
    output logic [NUM_CHANNELS-1:0]            saturated
);

    localparam int PROD_W = MAG_WIDTH + GAIN_WIDTH;
    localparam int RND_W  = PROD_W - GAIN_FRAC_BITS + 1;
    localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [GAIN_WIDTH-1:0] UNITY    = {{(GAIN_WIDTH-1){1'b0}}, 1'b1} << GAIN_FRAC_BITS;
    localparam logic [PROD_W:0]       HALF_LSB = {{PROD_W{1'b0}}, 1'b1} << (GAIN_FRAC_BITS - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

    trim_state_t state;
    trim_state_t next_state;

    logic [NUM_CHANNELS-1:0][MAG_WIDTH-1:0]  snap_mag;
    logic [NUM_CHANNELS-1:0][GAIN_WIDTH-1:0] pending_gain;
    logic [NUM_CHANNELS-1:0][GAIN_WIDTH-1:0] active_gain;
    logic [NUM_CHANNELS-1:0][MAG_WIDTH-1:0]  res_buf;
    logic [NUM_CHANNELS-1:0]                 sat_buf;

    logic [IDX_W-1:0]      issue_idx;
    logic [IDX_W-1:0]      wr_idx;
    logic [MAG_WIDTH-1:0]  op_mag;
    logic [GAIN_WIDTH-1:0] op_gain;
    logic [MULT_LATENCY:0] vpipe;
    logic [PROD_W-1:0]     product;

    logic                  start;
    logic [PROD_W:0]       rnd_sum;
    logic [RND_W-1:0]      rounded;
    logic                  rnd_sat;
    logic [MAG_WIDTH-1:0]  rnd_val;

    assign start = (state == IDLE) && strobe;
    assign busy  = (state != IDLE);

    fullMultiplier #(
        .A_WIDTH             (MAG_WIDTH),
        .B_WIDTH             (GAIN_WIDTH),
        .NUM_PIPELINE_LEVELS (MULT_LATENCY)
    ) u_mult (
        .clk (clk),
        .a   (op_mag),
        .b   (op_gain),
        .p   (product)
    );

    // Round half up and clamp to the magnitude range.
    // Adding half an LSB before truncation equals (p >> F) + p[F-1].
    always_comb begin
        rnd_sum = {1'b0, product} + HALF_LSB;
        rounded = rnd_sum[PROD_W:GAIN_FRAC_BITS];
        rnd_sat = |rounded[RND_W-1:MAG_WIDTH];
        rnd_val = rnd_sat ? '1 : rounded[MAG_WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: issue every channel, drain the pipeline, commit.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (strobe) next_state = ISSUE;
            ISSUE:   if (issue_idx == LAST_IDX) next_state = DRAIN;
            DRAIN:   if (vpipe[MULT_LATENCY] && (wr_idx == LAST_IDX)) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: gain registers, operand issue, rounding capture and commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_mag      <= '0;
            pending_gain  <= {NUM_CHANNELS{UNITY}};
            active_gain   <= {NUM_CHANNELS{UNITY}};
            res_buf       <= '0;
            sat_buf       <= '0;
            issue_idx     <= '0;
            wr_idx        <= '0;
            op_mag        <= '0;
            op_gain       <= '0;
            vpipe         <= '0;
            trimmed       <= '0;
            saturated     <= '0;
            trimmedToggle <= 1'b0;
        end else begin
            if (gainsStrobe) begin
                pending_gain <= gains;
            end
            if (start) begin
                snap_mag    <= magnitudes;
                active_gain <= gainsStrobe ? gains : pending_gain;
                issue_idx   <= '0;
                wr_idx      <= '0;
            end else if (state == ISSUE) begin
                issue_idx <= issue_idx + 1'b1;
            end
            op_mag  <= snap_mag[issue_idx];
            op_gain <= active_gain[issue_idx];
            vpipe   <= {vpipe[MULT_LATENCY-1:0], state == ISSUE};
            if (vpipe[MULT_LATENCY]) begin
                res_buf[wr_idx] <= rnd_val;
                sat_buf[wr_idx] <= rnd_sat;
                wr_idx          <= wr_idx + 1'b1;
            end
            if (state == COMMIT) begin
                trimmed       <= res_buf;
                saturated     <= sat_buf;
                trimmedToggle <= ~trimmedToggle;
            end
        end
    end

    // Sticky overrun flag; a strobe while busy wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (strobe && busy) begin
            overrun <= 1'b1;
        end else if (overrunClear) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trim_sequential.sv
// Scoreboard bench for trim_sequential: expected results are queued at the
// strobe edge and compared when trimmedToggle flips.
module tb_trim_sequential;

    localparam int N  = 4;
    localparam int MW = 26;
    localparam int GW = 27;

    localparam logic [GW*N-1:0] UNITY_ALL = {N{27'h4000000}};
    localparam logic [GW*N-1:0] HALF_ALL  = {N{27'h2000000}};
    localparam logic [GW-1:0]   MAXG      = 27'h7ffffff;

    typedef struct {
        logic [MW*N-1:0] trimmed;
        logic [N-1:0]    sat;
        int              start;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            strobe;
    logic [MW*N-1:0] magnitudes;
    logic [GW*N-1:0] gains;
    logic            gainsStrobe;
    logic            overrunClear;
    logic            busy;
    logic            overrun;
    logic            trimmedToggle;
    logic [MW*N-1:0] trimmed;
    logic [N-1:0]    saturated;

    int              n_tests = 0;
    int              n_fail  = 0;
    int              cyc     = 0;
    int              last_start;
    logic [GW*N-1:0] pend_m = UNITY_ALL;
    exp_t            sb[$];

    trim_sequential #(
        .NUM_CHANNELS   (N),
        .MAG_WIDTH      (MW),
        .GAIN_WIDTH     (GW),
        .GAIN_FRAC_BITS (26),
        .MULT_LATENCY   (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .strobe        (strobe),
        .magnitudes    (magnitudes),
        .gains         (gains),
        .gainsStrobe   (gainsStrobe),
        .overrunClear  (overrunClear),
        .busy          (busy),
        .overrun       (overrun),
        .trimmedToggle (trimmedToggle),
        .trimmed       (trimmed),
        .saturated     (saturated)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: round-half-up fixed-point scaling with clamp.
    function automatic exp_t model(input logic [MW*N-1:0] mags, input logic [GW*N-1:0] g);
        exp_t        e;
        logic [63:0] m;
        logic [63:0] gg;
        logic [63:0] p;
        logic [63:0] r;
        e.trimmed = '0;
        e.sat     = '0;
        e.start   = 0;
        for (int i = 0; i < N; i++) begin
            m  = 64'(mags[i*MW +: MW]);
            gg = 64'(g[i*GW +: GW]);
            p  = m * gg;
            r  = (p >> 26) + ((p >> 25) & 64'd1);
            if (r > 64'h3ffffff) begin
                e.sat[i]              = 1'b1;
                e.trimmed[i*MW +: MW] = '1;
            end else begin
                e.trimmed[i*MW +: MW] = r[MW-1:0];
            end
        end
        return e;
    endfunction

    // One-cycle pulse on the control inputs, starting and ending at a negedge.
    task automatic pulse(input bit s, input bit g, input logic [GW*N-1:0] gv,
                         input bit oc, input bit accept);
        exp_t e;
        strobe       = s;
        gainsStrobe  = g;
        gains        = gv;
        overrunClear = oc;
        @(posedge clk);
        #1;
        if (g) pend_m = gv;
        if (s && accept) begin
            e         = model(magnitudes, pend_m);
            e.start   = cyc;
            last_start = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        strobe       = 1'b0;
        gainsStrobe  = 1'b0;
        overrunClear = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 128'(sb.size()), 128'd0);
    endtask

    function automatic logic [MW*N-1:0] rand_mags();
        logic [MW*N-1:0] v;
        for (int i = 0; i < N; i++) v[i*MW +: MW] = MW'($urandom);
        return v;
    endfunction

    // Commit monitor: every toggle must match the oldest queued conversion.
    logic prev_toggle = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_toggle = trimmedToggle;
        end else if (trimmedToggle !== prev_toggle) begin
            prev_toggle = trimmedToggle;
            if (sb.size() == 0) begin
                check("unexpected_toggle", 128'd1, 128'd0);
            end else begin
                e = sb.pop_front();
                check("trimmed", 128'(trimmed), 128'(e.trimmed));
                check("saturated", 128'(saturated), 128'(e.sat));
                check("commit_latency", 128'(cyc - e.start), 128'd12);
            end
        end
    end

    initial begin
        logic [GW*N-1:0] g3;
        rst_n        = 1'b0;
        strobe       = 1'b0;
        gainsStrobe  = 1'b0;
        overrunClear = 1'b0;
        gains        = '0;
        magnitudes   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_overrun", 128'(overrun), 128'd0);
        check("rst_toggle", 128'(trimmedToggle), 128'd0);
        check("rst_trimmed", 128'(trimmed), 128'd0);
        check("rst_saturated", 128'(saturated), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unity gains pass magnitudes through unchanged.
        magnitudes = {26'h3ffffff, 26'd12345, 26'd0, 26'd1000};
        pulse(1, 0, '0, 0, 1);
        check("busy_after_strobe", 128'(busy), 128'd1);
        wait_done();
        check("busy_idle", 128'(busy), 128'd0);

        // Half gains loaded on the strobe edge itself; 1.5 and 2.5 round up.
        magnitudes = {26'd1, 26'd5, 26'd4, 26'd3};
        pulse(1, 1, HALF_ALL, 0, 1);
        wait_done();

        // Near-2.0 gain: channel 2 saturates, channel 0 does not.
        g3 = {27'h4000000, MAXG, 27'h4000000, MAXG};
        pulse(0, 1, g3, 0, 0);
        magnitudes = {26'h3ffffff, 26'h2000000, 26'd100, 26'd7};
        pulse(1, 0, '0, 0, 1);
        wait_done();

        // Overrun, gain update mid-conversion, back-to-back strobe.
        pulse(0, 1, UNITY_ALL, 0, 0);
        magnitudes = rand_mags();
        pulse(1, 0, '0, 0, 1);
        repeat (2) @(negedge clk);
        pulse(0, 1, HALF_ALL, 0, 0);
        @(negedge clk);
        pulse(1, 0, '0, 0, 0);
        check("overrun_set", 128'(overrun), 128'd1);
        for (int i = 0; i < 30 && cyc < last_start + 12; i++) @(negedge clk);
        magnitudes = rand_mags();
        pulse(1, 0, '0, 0, 1);
        check("back_to_back_busy", 128'(busy), 128'd1);
        repeat (2) @(negedge clk);
        pulse(1, 0, '0, 1, 0);
        check("overrun_set_wins", 128'(overrun), 128'd1);
        pulse(0, 0, '0, 1, 0);
        check("overrun_cleared", 128'(overrun), 128'd0);
        wait_done();

        // Reset in the middle of a conversion.
        magnitudes = rand_mags();
        pulse(1, 0, '0, 0, 1);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_toggle", 128'(trimmedToggle), 128'd0);
        check("midrst_trimmed", 128'(trimmed), 128'd0);
        check("midrst_saturated", 128'(saturated), 128'd0);
        sb.delete();
        pend_m = UNITY_ALL;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_toggle", 128'(trimmedToggle), 128'd0);
        check("post_rst_busy", 128'(busy), 128'd0);
        check("post_rst_trimmed", 128'(trimmed), 128'd0);

        // Gains are back to unity after reset.
        magnitudes = rand_mags();
        pulse(1, 0, '0, 0, 1);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
